costas_loop_filter: RTL and testbench
=====================================

Name: costas_loop_filter

Overview:
Proportional-integral loop filter for the Costas carrier-recovery loop. It takes signed phase-error samples from the phase detector and produces the 32-bit frequency control word (Freq) that drives the DDS phase accumulator. The output is the centre frequency word plus a proportional correction and an integrated correction. The block is pipelined, and its integrator saturates and supports hold and clear.

Parameters:
ERR_WIDTH, 16, width of signed phase-error input
ACC_WIDTH, 48, integrator width; must be >= ERR_WIDTH+16
KP_SHIFT, 8, arithmetic right shift applied to the proportional product
KI_SHIFT, 16, arithmetic right shift applied to the integrator before the output sum

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
err_tdata  in  ERR_WIDTH  signed phase-error sample
err_tvalid  in  1  error sample strobe; one sample per high cycle, no backpressure
kp  in  16  signed proportional gain, sampled with each error sample
ki  in  16  signed integral gain, sampled with each error sample
Freq_base  in  32  unsigned centre frequency word, sampled in stage 3
loop_hold  in  1  freeze integrator; proportional path still active
int_clear  in  1  synchronous integrator clear
Freq  out  32  frequency control word to the DDS, held between updates
freq_valid  out  1  one-cycle pulse when Freq updates
int_sat  out  1  high while integrator sits at either rail

Behaviour:
- Reset (rst_n=0 at a clk edge) clears everything: Freq=0, freq_valid=0, int_sat=0, integrator=0, all pipeline valids=0. Reset mid-operation discards in-flight samples, and no freq_valid follows.
- Stage 1 (on err_tvalid): register p1 = err*kp and i1 = err*ki, each a signed (ERR_WIDTH+16)-bit full-precision product. Register v1.
- Stage 2 (on v1):
  - int_clear=1: integrator <= 0. Clear has priority over hold and over a concurrent sample.
  - Else loop_hold=0: integrator <= sat(integrator + sext(i1)). The sum is computed in ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Else (hold): integrator unchanged.
  - prop2 <= p1 >>> KP_SHIFT, sign-extended or truncated to 32 bits. Register v2.
- int_clear acts in any cycle, not only on v1.
- int_sat is registered; it is 1 whenever the integrator equals either rail.
- Stage 3 (on v2): Freq <= Freq_base + prop2 + low 32 bits of (integrator >>> KI_SHIFT), sign-extended, modulo 2^32. Wrap-around is intended and matches phase-word arithmetic. freq_valid=1 for exactly this cycle.
- Stage 3 uses the integrator value updated by the same sample.
- Latency: freq_valid rises 3 clk after err_tvalid. Throughput is one sample per clock; back-to-back valids produce back-to-back pulses.
- Freq holds its last value while no sample is in flight.
- kp/ki changes affect only samples accepted after the change. Freq_base changes appear on the next output.
- err_tdata is ignored when err_tvalid=0.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release -> Freq=0x00000000, freq_valid=0, int_sat=0; no pulse with err_tvalid=0.
2. Proportional only: kp=256, ki=0, Freq_base=0x10000000, single err=+100 -> exactly 3 cycles later Freq=0x10000064 and freq_valid high for 1 cycle.
3. Negative wrap: Freq_base=0, kp=256, ki=0, err=-1 -> Freq=0xFFFFFFFF.
4. Integrator: kp=0, ki=0x4000, err=4 on 5 consecutive cycles -> 5 consecutive pulses with Freq=base+1..base+5. Then loop_hold=1 and 3 more samples -> Freq stays base+5. Then int_clear pulse and a sample with err=0 -> Freq=base.
5. Saturation (ACC_WIDTH=34): ki=0x7FFF, err=0x7FFF, 10 samples -> int_sat rises on the sample that reaches 2^33-1, and Freq stops increasing. Then err=-0x7FFF -> int_sat falls and Freq decreases.
6. Simultaneous/mid-op: int_clear in the same cycle v1 is set -> that output equals base+prop only. Assert rst_n=0 with 2 samples in flight -> no freq_valid, Freq=0.

Source files
------------

// File: rtl/costas_loop_filter.sv
// costas_loop_filter: pipelined PI loop filter producing the DDS frequency control word
module costas_loop_filter #(
    parameter int ERR_WIDTH = 16,
    parameter int ACC_WIDTH = 48,
    parameter int KP_SHIFT  = 8,
    parameter int KI_SHIFT  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ERR_WIDTH-1:0] err_tdata,
    input  logic                 err_tvalid,
    input  logic [15:0]          kp,
    input  logic [15:0]          ki,
    input  logic [31:0]          Freq_base,
    input  logic                 loop_hold,
    input  logic                 int_clear,
    output logic [31:0]          Freq,
    output logic                 freq_valid,
    output logic                 int_sat
);
    localparam int PW = ERR_WIDTH + 16;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                 v1_q, v1_d, v2_q, v2_d, fv_q, fv_d, sat_q, sat_d;
    logic [PW-1:0]        p1_q, p1_d, i1_q, i1_d;
    logic [31:0]          prop2_q, prop2_d, freq_q, freq_d;
    logic [ACC_WIDTH-1:0] integ_q, integ_d, integ_sat;
    logic [ACC_WIDTH:0]   sum;
    logic signed [PW+31:0]        prop_ext;
    logic signed [ACC_WIDTH+31:0] int_ext;
    logic                 unused_bits;

    // stage 1: full-precision gain products, captured only on a valid sample
    always_comb begin
        v1_d = err_tvalid;
        p1_d = err_tvalid ? $signed({{16{err_tdata[ERR_WIDTH-1]}}, err_tdata}) * $signed({{ERR_WIDTH{kp[15]}}, kp}) : p1_q;
        i1_d = err_tvalid ? $signed({{16{err_tdata[ERR_WIDTH-1]}}, err_tdata}) * $signed({{ERR_WIDTH{ki[15]}}, ki}) : i1_q;
    end

    // stage 2: saturating integrator (clear beats hold beats accumulate) and scaled proportional term
    always_comb begin
        sum       = {integ_q[ACC_WIDTH-1], integ_q} + {{(ACC_WIDTH+1-PW){i1_q[PW-1]}}, i1_q};
        integ_sat = (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
        integ_d   = int_clear ? '0 : (v1_q && !loop_hold) ? integ_sat : integ_q;
        sat_d     = (integ_d == ACC_MAX) || (integ_d == ACC_MIN);
        prop_ext  = $signed({{32{p1_q[PW-1]}}, p1_q}) >>> KP_SHIFT;
        prop2_d   = v1_q ? prop_ext[31:0] : prop2_q;
        v2_d      = v1_q;
    end

    // stage 3: output sum wraps modulo 2^32 like a phase word, held between samples
    always_comb begin
        int_ext     = $signed({{32{integ_q[ACC_WIDTH-1]}}, integ_q}) >>> KI_SHIFT;
        freq_d      = v2_q ? Freq_base + prop2_q + int_ext[31:0] : freq_q;
        fv_d        = v2_q;
        unused_bits = ^{prop_ext[PW+31:32], int_ext[ACC_WIDTH+31:32]};
    end

    // pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            fv_q    <= 1'b0;
            sat_q   <= 1'b0;
            p1_q    <= '0;
            i1_q    <= '0;
            prop2_q <= '0;
            integ_q <= '0;
            freq_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            fv_q    <= fv_d;
            sat_q   <= sat_d;
            p1_q    <= p1_d;
            i1_q    <= i1_d;
            prop2_q <= prop2_d;
            integ_q <= integ_d;
            freq_q  <= freq_d;
        end
    end

    assign Freq       = freq_q;
    assign freq_valid = fv_q;
    assign int_sat    = sat_q;
endmodule

// File: tb/tb_costas_loop_filter.sv
// tb_costas_loop_filter: model-based and directed checks of the PI loop filter at two integrator widths
module tb_costas_loop_filter;
    logic        clk = 1'b0;
    logic        rst_n, err_tvalid, loop_hold, int_clear;
    logic [15:0] err_tdata, kp, ki;
    logic [31:0] Freq_base;
    logic [31:0] freq_a, freq_b;
    logic        fv_a, fv_b, sat_a, sat_b;
    int          tests = 0, failed = 0;
    bit          chk_en = 1'b0;
    logic [31:0] qa[$], qb[$];

    // arithmetic model state, index 0 = 48-bit integrator, 1 = 34-bit integrator
    longint      integ[2];
    longint      s1_p, s1_i;
    logic [31:0] s2_p;
    bit          s1_v, s2_v;
    logic [31:0] m_freq[2];
    bit          m_fv;
    bit          m_sat[2];
    int          acc_w[2] = '{48, 34};

    always #5 clk = ~clk;

    costas_loop_filter u48 (
        .clk(clk), .rst_n(rst_n), .err_tdata(err_tdata), .err_tvalid(err_tvalid),
        .kp(kp), .ki(ki), .Freq_base(Freq_base), .loop_hold(loop_hold), .int_clear(int_clear),
        .Freq(freq_a), .freq_valid(fv_a), .int_sat(sat_a)
    );

    costas_loop_filter #(.ACC_WIDTH(34)) u34 (
        .clk(clk), .rst_n(rst_n), .err_tdata(err_tdata), .err_tvalid(err_tvalid),
        .kp(kp), .ki(ki), .Freq_base(Freq_base), .loop_hold(loop_hold), .int_clear(int_clear),
        .Freq(freq_b), .freq_valid(fv_b), .int_sat(sat_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: integer arithmetic of the filter equations, 3-sample latency
    always @(posedge clk) begin : model
        longint sum, mx, ish, pp;
        if (!rst_n) begin
            s1_v = 0; s2_v = 0; m_fv = 0; s1_p = 0; s1_i = 0; s2_p = '0;
            for (int d = 0; d < 2; d++) begin
                integ[d] = 0; m_freq[d] = '0; m_sat[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (s2_v) begin
                    ish = integ[d] >>> 16;
                    m_freq[d] = Freq_base + s2_p + ish[31:0];
                end
                mx = (64'sd1 <<< (acc_w[d] - 1)) - 64'sd1;
                if (int_clear) integ[d] = 0;
                else if (s1_v && !loop_hold) begin
                    sum = integ[d] + s1_i;
                    integ[d] = sum > mx ? mx : (sum < -mx - 1 ? -mx - 1 : sum);
                end
                m_sat[d] = (integ[d] == mx) || (integ[d] == -mx - 1);
            end
            m_fv = s2_v;
            s2_v = s1_v;
            pp = s1_p >>> 8;
            s2_p = pp[31:0];
            s1_v = err_tvalid;
            if (err_tvalid) begin
                s1_p = longint'($signed(err_tdata)) * longint'($signed(kp));
                s1_i = longint'($signed(err_tdata)) * longint'($signed(ki));
            end
        end
    end

    // per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("freq48", freq_a, m_freq[0]);
            check("valid48", {31'd0, fv_a}, {31'd0, m_fv});
            check("sat48", {31'd0, sat_a}, {31'd0, m_sat[0]});
            check("freq34", freq_b, m_freq[1]);
            check("valid34", {31'd0, fv_b}, {31'd0, m_fv});
            check("sat34", {31'd0, sat_b}, {31'd0, m_sat[1]});
        end
    end

    // collect every output pulse for the directed checks
    always @(negedge clk) begin
        if (fv_a) qa.push_back(freq_a);
        if (fv_b) qb.push_back(freq_b);
    end

    task automatic idle(input int n);
        err_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] e);
        err_tdata  = e;
        err_tvalid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; err_tvalid = 1'b0; err_tdata = '0; kp = '0; ki = '0;
        Freq_base = '0; loop_hold = 1'b0; int_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_freq", freq_a, 32'h0);
        check("rst_valid", {31'd0, fv_a}, 32'h0);
        check("rst_sat", {31'd0, sat_a}, 32'h0);
        idle(4);
        check("rst_no_pulse", qa.size(), 32'd0);

        kp = 16'd256; ki = 16'd0; Freq_base = 32'h1000_0000;
        send(16'd100);
        err_tvalid = 1'b0;
        @(negedge clk);
        check("prop_early", {31'd0, fv_a}, 32'h0);
        @(negedge clk);
        check("prop_valid", {31'd0, fv_a}, 32'h1);
        check("prop_freq", freq_a, 32'h1000_0064);
        @(negedge clk);
        check("prop_pulse_end", {31'd0, fv_a}, 32'h0);
        check("prop_hold", freq_a, 32'h1000_0064);

        Freq_base = 32'h0;
        send(16'hFFFF);
        idle(4);
        check("neg_wrap", freq_a, 32'hFFFF_FFFF);

        Freq_base = 32'h0100_0000; kp = 16'd0; ki = 16'h4000;
        qa.delete();
        repeat (5) send(16'd4);
        idle(4);
        check("int_count", qa.size(), 32'd5);
        for (int k = 0; k < qa.size() && k < 5; k++) check("int_ramp", qa[k], 32'h0100_0000 + k + 1);
        loop_hold = 1'b1;
        qa.delete();
        repeat (3) send(16'd4);
        idle(4);
        loop_hold = 1'b0;
        check("hold_count", qa.size(), 32'd3);
        for (int k = 0; k < qa.size() && k < 3; k++) check("hold_freq", qa[k], 32'h0100_0005);
        int_clear = 1'b1;
        idle(1);
        int_clear = 1'b0;
        qa.delete();
        send(16'd0);
        idle(4);
        check("clear_count", qa.size(), 32'd1);
        if (qa.size() > 0) check("clear_freq", qa[0], 32'h0100_0000);

        Freq_base = 32'h0; kp = 16'd0; ki = 16'h7FFF;
        int_clear = 1'b1;
        idle(1);
        int_clear = 1'b0;
        qb.delete();
        repeat (10) send(16'h7FFF);
        idle(4);
        check("sat_count", qb.size(), 32'd10);
        if (qb.size() == 10) begin
            check("sat_pre", qb[7], 32'h0001_FFF8);
            check("sat_rail", qb[8], 32'h0001_FFFF);
            check("sat_flat", qb[9], 32'h0001_FFFF);
        end
        check("sat_flag", {31'd0, sat_b}, 32'h1);
        qb.delete();
        send(16'h8001);
        idle(4);
        check("desat_count", qb.size(), 32'd1);
        if (qb.size() > 0) check("desat_freq", qb[0], 32'h0001_C000);
        check("desat_flag", {31'd0, sat_b}, 32'h0);

        kp = 16'd256; ki = 16'h4000; Freq_base = 32'h0000_1000;
        qa.delete(); qb.delete();
        send(16'd100);
        err_tvalid = 1'b0;
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
        idle(4);
        check("clr_v1_count", qa.size(), 32'd1);
        if (qa.size() > 0) check("clr_v1_48", qa[0], 32'h0000_1064);
        if (qb.size() > 0) check("clr_v1_34", qb[0], 32'h0000_1064);

        qa.delete();
        send(16'd5);
        send(16'd6);
        err_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_freq48", freq_a, 32'h0);
        check("midrst_freq34", freq_b, 32'h0);
        check("midrst_valid", {31'd0, fv_a}, 32'h0);
        rst_n = 1'b1;
        idle(4);
        check("midrst_no_pulse", qa.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
